// File: rtl/echo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : echo_pkg
//  Description : Shared types for the echo indication deframer: tag width,
//                80-bit output record layout and deframer FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package echo_pkg;

    localparam int ECHO_TAG_W = 16;

    // Record as presented to the pipe consumer: [79:64] tag, [63:32] meth, [31:0] v
    typedef struct packed {
        logic [ECHO_TAG_W-1:0] tag;
        logic [31:0]           meth;
        logic [31:0]           v;
    } echo_record_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } echo_state_t;

endpackage
`default_nettype wire

// File: rtl/echo_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : echo_out_reg
//  Description : Single-entry output register. A load wins over a drain in
//                the same cycle, so a draining record is replaced without a
//                bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_out_reg
    import echo_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  echo_record_t i_data,
    input  logic         i_drain,
    output logic         o_full,
    output echo_record_t o_data
);

    logic         r_full;
    echo_record_t r_data;

    // Hold one record; reload on completion, empty on drain without reload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/echo_indication_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : echo_indication_deframer
//  Description : Parses 32-bit transport beats (header {tag, length} followed
//                by payload words) into 80-bit {tag, meth, v} records.
//                Unknown tags and oversized messages are skipped.
//                Optional macro ECHO_DEFRAMER_ERRCNT_EN adds a saturating
//                dropped-message counter on port err_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_indication_deframer
    import echo_pkg::*;
#(
    parameter int MAX_WORDS = 2,
    parameter int KNOWN_TAG = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        beat_enq__ENA,
    input  logic [31:0] beat_enq_v,
    output logic        beat_enq__RDY,
    output logic        pipe_enq__ENA,
    output logic [79:0] pipe_enq_v,
    input  logic        pipe_enq__RDY
`ifdef ECHO_DEFRAMER_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [ECHO_TAG_W-1:0] c_known_tag = ECHO_TAG_W'(KNOWN_TAG);
    localparam logic [15:0]           c_max_words = 16'(MAX_WORDS);

    echo_state_t  r_state, w_state_nxt;
    logic [15:0]  r_cnt, w_cnt_nxt;     // PAYLOAD: words taken; DISCARD: words left
    logic [15:0]  r_len, w_len_nxt;
    logic [31:0]  r_meth, w_meth_nxt;
    logic [31:0]  r_v, w_v_nxt;

    logic                  w_beat;
    logic [ECHO_TAG_W-1:0] w_hdr_tag;
    logic [15:0]           w_hdr_len;
    logic                  w_would_complete;
    logic                  w_full;
    logic                  w_drain;
    logic                  w_load;
    logic                  w_drop;
    echo_record_t          w_rec;
    echo_record_t          w_out;

    assign w_hdr_tag = beat_enq_v[31:16];
    assign w_hdr_len = beat_enq_v[15:0];
    assign w_drain   = w_full && pipe_enq__RDY;
    assign w_beat    = beat_enq__ENA && beat_enq__RDY;

    // Stall only when the offered beat would finish a record and the full
    // output register cannot make room this cycle
    always_comb begin
        w_would_complete = 1'b0;
        if (r_state == ST_IDLE)
            w_would_complete = (w_hdr_tag == c_known_tag) && (w_hdr_len == 16'd0);
        else if (r_state == ST_PAYLOAD)
            w_would_complete = ((r_cnt + 16'd1) == r_len);
        beat_enq__RDY = !(w_would_complete && w_full && !w_drain);
    end

    // Deframer state register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_meth  <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_meth  <= w_meth_nxt;
            r_v     <= w_v_nxt;
        end
    end

    // Header decode, payload assembly and record completion
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_meth_nxt  = r_meth;
        w_v_nxt     = r_v;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        w_rec       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_beat) begin
                    if (w_hdr_len == 16'd0) begin
                        // Empty message: known tag yields an all-zero record
                        if (w_hdr_tag == c_known_tag) begin
                            w_load   = 1'b1;
                            w_rec.tag = c_known_tag;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end else if ((w_hdr_tag == c_known_tag) && (w_hdr_len <= c_max_words)) begin
                        w_state_nxt = ST_PAYLOAD;
                        w_cnt_nxt   = '0;
                        w_len_nxt   = w_hdr_len;
                        w_meth_nxt  = '0;
                        w_v_nxt     = '0;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                        w_cnt_nxt   = w_hdr_len;
                        w_drop      = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_beat) begin
                    // Only the first two words carry fields; any extra are skipped
                    if (r_cnt == 16'd0) w_meth_nxt = beat_enq_v;
                    if (r_cnt == 16'd1) w_v_nxt    = beat_enq_v;
                    w_cnt_nxt = r_cnt + 16'd1;
                    if (w_cnt_nxt == r_len) begin
                        w_state_nxt = ST_IDLE;
                        w_load      = 1'b1;
                        w_rec.tag   = c_known_tag;
                        w_rec.meth  = w_meth_nxt;
                        w_rec.v     = w_v_nxt;
                    end
                end
            end
            ST_DISCARD: begin
                if (w_beat) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                    if (r_cnt == 16'd1) w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    echo_out_reg u_out_reg (
        .clk     (CLK),
        .rst_n   (nRST),
        .i_load  (w_load),
        .i_data  (w_rec),
        .i_drain (w_drain),
        .o_full  (w_full),
        .o_data  (w_out)
    );

    assign pipe_enq__ENA = w_full;
    assign pipe_enq_v    = w_out;

`ifdef ECHO_DEFRAMER_ERRCNT_EN
    logic [7:0] r_err;

    // Saturating count of dropped messages
    always_ff @(posedge CLK) begin
        if (!nRST)
            r_err <= '0;
        else if (w_drop && (r_err != 8'hFF))
            r_err <= r_err + 8'd1;
    end

    assign err_count = r_err;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

endmodule
`default_nettype wire

// File: doc/echo_indication_deframer.md
ECHO_INDICATION_DEFRAMER -- requirements
Module: echo_indication_deframer

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 2, max payload words per message.
REQ-002 SHALL have parameter KNOWN_TAG, default 1, tag value of the heard indication.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port beat_enq__ENA  input  1  transport beat valid.
REQ-006 SHALL have port beat_enq$v  input  32  transport beat data.
REQ-007 SHALL have port beat_enq__RDY  output  1  beat accepted when high with __ENA.
REQ-008 SHALL have port pipe_enq__ENA  output  1  assembled record valid toward the pipe consumer.
REQ-009 SHALL have port pipe_enq$v  output  80  record: [79:64] tag, [63:32] meth, [31:0] v.
REQ-010 SHALL have port pipe_enq__RDY  input  1  downstream consumer accepts record.
REQ-011 SHALL have port err_count  output  8  dropped-message count; present only with ECHO_DEFRAMER_ERRCNT_EN.

Function
REQ-012 Beat transfer occurs on a cycle with beat_enq__ENA && beat_enq__RDY; record transfer on pipe_enq__ENA && pipe_enq__RDY.
REQ-013 Header beat: [31:16] tag, [15:0] payload length L in words.
REQ-014 FSM states: IDLE, PAYLOAD, DISCARD; IDLE consumes headers.
REQ-015 IDLE, header with tag==KNOWN_TAG, 1<=L<=MAX_WORDS -> PAYLOAD, word counter=0, assembly buffer cleared.
REQ-016 IDLE, header with L==0 -> stay IDLE; tag==KNOWN_TAG yields record with meth=v=0, otherwise dropped.
REQ-017 IDLE, unknown tag or L>MAX_WORDS with L>0 -> DISCARD; remaining counter=L; message counted as dropped.
REQ-018 PAYLOAD: word 0 -> meth, word 1 -> v; missing words (L<MAX_WORDS) stay zero; on L-th word -> IDLE and record issued.
REQ-019 DISCARD: each beat decrements counter; at last beat -> IDLE; no record issued.
REQ-020 Output is a single-entry register; record becomes valid the cycle after the completing beat (latency 1).
REQ-021 beat_enq__RDY SHALL be low only when the next beat would complete a record and the output register is full and not draining this cycle; otherwise high.
REQ-022 Simultaneous drain and completion: output register reloads same cycle, pipe_enq__ENA stays high, no bubble.
REQ-023 pipe_enq$v SHALL be stable while pipe_enq__ENA high and __RDY low.
REQ-024 Records SHALL leave in message arrival order; none lost or duplicated.

Reset
REQ-025 nRST low at a clock edge: state=IDLE, counters=0, output register empty, pipe_enq__ENA=0, pipe_enq$v=0, err_count=0.
REQ-026 nRST low mid-message SHALL abandon the partial message and the buffered record without emitting them.
REQ-027 beat_enq__RDY SHALL be 1 in the first cycle after reset release.

Configuration
REQ-028 ECHO_DEFRAMER_ERRCNT_EN defined: err_count increments per dropped message (REQ-016 unknown, REQ-017), saturating at 255.
REQ-029 ECHO_DEFRAMER_ERRCNT_EN undefined: err_count port and counter absent; other behaviour identical.

Structure
REQ-030 Package echo_pkg SHALL hold ECHO_TAG_W=16, the 80-bit echo_record_t typedef (tag, meth, v) and the FSM state enum.
REQ-031 The single-entry output register SHALL be sub-module echo_out_reg (load, drain, full), instantiated once.

Verification
REQ-032 Beats 0x0001_0002, 0x1111_1111, 0x2222_2222, pipe RDY=1 -> one record tag=1 meth=0x11111111 v=0x22222222 one cycle after third beat.
REQ-033 Header 0x0005_0003 + 3 beats -> no record; err_count=1 (macro on).
REQ-034 Header 0x0001_0004 (L>MAX_WORDS) + 4 beats, then valid message -> only second message emitted; err_count=1.
REQ-035 pipe RDY held 0, two valid messages streamed -> first record held stable, beat_enq__RDY drops before second message's last beat; releasing RDY drains both in order.
REQ-036 nRST pulsed after header+1 payload beat -> no record; next full message emitted correctly.
REQ-037 Header 0x0001_0000 -> record tag=1 meth=0 v=0 next cycle.
